// File: rtl/uart_regs_pkg.sv
// Shared types and register-map constants for the banco_registros_uart peripheral.
// The optional overrun flag (macro OVERRUN_FLAG_EN) uses control bit BIT_OVERRUN.
package uart_regs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_estado_t;

   localparam int unsigned BIT_SEND    = 0;
   localparam int unsigned BIT_NEW_RX  = 1;
   localparam int unsigned BIT_OVERRUN = 2;

   localparam logic ADDR_TX = 1'b0;
   localparam logic ADDR_RX = 1'b1;

   // Clock cycles per serial bit; integer division, caller guarantees the result is >= 2.
   function automatic int unsigned calc_cpb(input int unsigned frec, input int unsigned baud);
      return frec / baud;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit, CPB cycles each.
// The shifter keeps its own copy of the byte so later TX-register writes leave a frame intact.
module uart_tx
   import uart_regs_pkg::*;
#(
   parameter int unsigned CPB = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] dato_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int unsigned CntW = $clog2(CPB);

   tx_estado_t      r_estado, w_estado_d;
   logic [CntW-1:0] r_cnt, w_cnt_d;
   logic [2:0]      r_idx, w_idx_d;
   logic [7:0]      r_shift, w_shift_d;
   logic            r_tx, w_tx_d;
   logic            w_fin_bit;
   logic            w_done;

   assign w_fin_bit = (r_cnt == CntW'(CPB - 1));

   always_comb begin
      w_estado_d = r_estado;
      w_cnt_d    = r_cnt;
      w_idx_d    = r_idx;
      w_shift_d  = r_shift;
      w_tx_d     = r_tx;
      w_done     = 1'b0;
      unique case (r_estado)
         IDLE: begin
            w_tx_d = 1'b1;
            if (start_i) begin
               w_estado_d = START;
               w_shift_d  = dato_i;
               w_cnt_d    = '0;
               w_tx_d     = 1'b0;
            end
         end
         START: begin
            if (w_fin_bit) begin
               w_estado_d = DATA;
               w_cnt_d    = '0;
               w_idx_d    = '0;
               w_tx_d     = r_shift[0];
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         DATA: begin
            if (w_fin_bit) begin
               w_cnt_d = '0;
               if (r_idx == 3'd7) begin
                  w_estado_d = STOP;
                  w_tx_d     = 1'b1;
               end else begin
                  w_idx_d = r_idx + 1'b1;
                  w_tx_d  = r_shift[w_idx_d];
               end
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         STOP: begin
            if (w_fin_bit) begin
               // Combinational so the top clears send on the very edge the frame ends.
               w_done     = 1'b1;
               w_estado_d = IDLE;
               w_cnt_d    = '0;
               w_tx_d     = 1'b1;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: begin
            w_estado_d = IDLE;
            w_tx_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_estado <= IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
      end else begin
         r_estado <= w_estado_d;
         r_cnt    <= w_cnt_d;
         r_idx    <= w_idx_d;
         r_shift  <= w_shift_d;
         r_tx     <= w_tx_d;
      end
   end

   assign tx_o   = r_tx;
   assign busy_o = (r_estado != IDLE);
   assign done_o = w_done;

endmodule

// File: rtl/banco_registros_uart.sv
// Register-mapped UART: control/TX/RX registers on the wr/reg_sel/addr bus plus an 8N1 transmitter.
// Define OVERRUN_FLAG_EN to add the sticky overrun flag at control bit 2.
module banco_registros_uart
   import uart_regs_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_i,
   input  logic        reg_sel_i,
   input  logic        addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] mux_o,
   output logic        tx_o,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i
);

   localparam int unsigned CPB = calc_cpb(CLK_FREQ, BAUD);

   logic        r_send;
   logic        r_new_rx;
   logic [7:0]  r_tx_data;
   logic [7:0]  r_rx_data;
   logic        w_wr_ctrl;
   logic        w_wr_tx;
   logic        w_start;
   logic        w_busy;
   logic        w_done;
   logic [31:0] w_ctrl;
   logic        w_unused_data;

   assign w_wr_ctrl     = wr_i & ~reg_sel_i;
   assign w_wr_tx       = wr_i & reg_sel_i & (addr_i == ADDR_TX);
   // A send that lands on the frame's final edge still sees busy and is dropped.
   assign w_start       = w_wr_ctrl & data_i[BIT_SEND] & ~w_busy;
   assign w_unused_data = ^data_i[31:2];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_send    <= 1'b0;
         r_new_rx  <= 1'b0;
         r_tx_data <= '0;
         r_rx_data <= '0;
      end else begin
         if (w_start) begin
            r_send <= 1'b1;
         end else if (w_done) begin
            r_send <= 1'b0;
         end
         if (rx_valid_i) begin
            r_new_rx  <= 1'b1;
            r_rx_data <= rx_data_i;
         end else if (w_wr_ctrl && !data_i[BIT_NEW_RX]) begin
            r_new_rx <= 1'b0;
         end
         if (w_wr_tx) begin
            r_tx_data <= data_i[7:0];
         end
      end
   end

`ifdef OVERRUN_FLAG_EN
   logic r_overrun;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_overrun <= 1'b0;
      end else if (rx_valid_i && r_new_rx) begin
         r_overrun <= 1'b1;
      end else if (w_wr_ctrl && !data_i[BIT_OVERRUN]) begin
         r_overrun <= 1'b0;
      end
   end
`endif

   always_comb begin
      w_ctrl             = '0;
      w_ctrl[BIT_SEND]   = r_send;
      w_ctrl[BIT_NEW_RX] = r_new_rx;
`ifdef OVERRUN_FLAG_EN
      w_ctrl[BIT_OVERRUN] = r_overrun;
`endif
      if (!reg_sel_i) begin
         mux_o = w_ctrl;
      end else if (addr_i == ADDR_RX) begin
         mux_o = {24'd0, r_rx_data};
      end else begin
         mux_o = {24'd0, r_tx_data};
      end
   end

   uart_tx #(
      .CPB(CPB)
   ) u_uart_tx (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(w_start),
      .dato_i (r_tx_data),
      .tx_o   (tx_o),
      .busy_o (w_busy),
      .done_o (w_done)
   );

endmodule

// File: tb/tb_banco_registros_uart.sv
// Bench for banco_registros_uart: frame-level reference model checked every cycle, plus directed
// literal checks. Build with OVERRUN_FLAG_EN defined to cover the overrun flag.
module tb_banco_registros_uart;

   localparam int unsigned CLK_FREQ = 40;
   localparam int unsigned BAUD     = 10;
   localparam int          CPB      = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        wr_i;
   logic        reg_sel_i;
   logic        addr_i;
   logic [31:0] data_i;
   logic [31:0] mux_o;
   logic        tx_o;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;

   int n_chk  = 0;
   int n_fail = 0;

   banco_registros_uart #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .wr_i      (wr_i),
      .reg_sel_i (reg_sel_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .mux_o     (mux_o),
      .tx_o      (tx_o),
      .rx_data_i (rx_data_i),
      .rx_valid_i(rx_valid_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register contents plus frame position counted in cycles since acceptance.
   bit         m_valid = 1'b0;
   bit         m_send, m_new_rx, m_ovr, m_busy;
   logic [7:0] m_tx_data, m_rx_data, m_byte;
   int         m_k;

   always @(posedge clk) begin
      bit accept, ovr_set;
      if (!rst_i) begin
         m_valid = 1'b1;
         m_send = 0; m_new_rx = 0; m_ovr = 0; m_busy = 0;
         m_tx_data = 0; m_rx_data = 0; m_byte = 0; m_k = 0;
      end else if (m_valid) begin
         accept  = wr_i && !reg_sel_i && data_i[0] && !m_busy;
         ovr_set = rx_valid_i && m_new_rx;
         if (m_busy) begin
            m_k++;
            if (m_k == 10 * CPB) begin
               m_busy = 0;
               m_send = 0;
            end
         end
         if (accept) begin
            m_busy = 1; m_k = 0; m_byte = m_tx_data; m_send = 1;
         end
         if (wr_i && reg_sel_i && !addr_i) m_tx_data = data_i[7:0];
         if (rx_valid_i) begin
            m_rx_data = rx_data_i;
            m_new_rx  = 1;
         end else if (wr_i && !reg_sel_i && !data_i[1]) begin
            m_new_rx = 0;
         end
         if (ovr_set) m_ovr = 1;
         else if (wr_i && !reg_sel_i && !data_i[2]) m_ovr = 0;
      end
   end

   function automatic logic exp_tx();
      if (!m_busy) return 1'b1;
      if (m_k < CPB) return 1'b0;
      if (m_k < 9 * CPB) return m_byte[(m_k - CPB) / CPB];
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_mux();
      logic [31:0] c;
      c = 0;
      c[0] = m_send;
      c[1] = m_new_rx;
`ifdef OVERRUN_FLAG_EN
      c[2] = m_ovr;
`endif
      if (!reg_sel_i) return c;
      if (addr_i) return {24'd0, m_rx_data};
      return {24'd0, m_tx_data};
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_tx", {31'd0, tx_o}, {31'd0, exp_tx()});
         if (!wr_i) chk("model_mux", mux_o, exp_mux());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic sel, input logic a, input logic [31:0] d);
      wr_i = 1; reg_sel_i = sel; addr_i = a; data_i = d;
      tick();
      wr_i = 0; data_i = 0;
   endtask

   task automatic rd_chk(input string name, input logic sel, input logic a, input logic [31:0] exp);
      reg_sel_i = sel; addr_i = a;
      @(negedge clk);
      chk(name, mux_o, exp);
      chk({name, "_tx"}, {31'd0, tx_o}, 32'd1);
      tick();
   endtask

   // Walks a frame from its accepting edge; sym[i] is the line level for bit-slot i.
   task automatic frame_check(input string name, input logic [9:0] sym, input int ncyc,
                              input int tx_k, input logic [7:0] tx_v, input int ctrl_k);
      for (int k = 0; k < ncyc; k++) begin
         wr_i = 0; reg_sel_i = 0; addr_i = 0; data_i = 0;
         @(negedge clk);
         chk(name, {31'd0, tx_o}, {31'd0, sym[k / CPB]});
         chk({name, "_send"}, {31'd0, mux_o[0]}, 32'd1);
         if (k == tx_k) begin
            wr_i = 1; reg_sel_i = 1; addr_i = 0; data_i = {24'd0, tx_v};
         end else if (k == ctrl_k) begin
            wr_i = 1; reg_sel_i = 0; data_i = 32'd1;
         end
         tick();
      end
      wr_i = 0; reg_sel_i = 0; data_i = 0;
   endtask

   initial begin
      rst_i = 0; wr_i = 0; reg_sel_i = 0; addr_i = 0; data_i = 0;
      rx_data_i = 0; rx_valid_i = 0;
      tick(); tick();
      rst_i = 1;

      rd_chk("rst_ctrl", 0, 0, 32'h0);
      rd_chk("rst_txd", 1, 0, 32'h0);
      rd_chk("rst_rxd", 1, 1, 32'h0);

      // 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop
      wr_reg(1, 0, 32'hA5);
      wr_reg(0, 0, 32'h1);
      frame_check("frame_a5", 10'b1_10100101_0, 40, -1, 8'h00, -1);
      rd_chk("a5_send_clr", 0, 0, 32'h0);

      // Busy send at cycle 10 ignored; TX rewrite mid-frame does not alter the frame
      wr_reg(0, 0, 32'h1);
      frame_check("frame_a5_busy", 10'b1_10100101_0, 40, 4, 8'hFF, 9);
      rd_chk("busy_send_clr", 0, 0, 32'h0);

      // 0xFF frame; a send on the final edge is dropped, the next cycle's is accepted
      wr_reg(0, 0, 32'h1);
      frame_check("frame_ff", 10'b1_11111111_0, 40, -1, 8'h00, 39);
      rd_chk("edge_send_ign", 0, 0, 32'h0);
      wr_reg(0, 0, 32'h1);
      frame_check("frame_ff_pre_rst", 10'b1_11111111_0, 15, -1, 8'h00, -1);
      rst_i = 0;
      tick();
      rst_i = 1;
      rd_chk("mid_rst_ctrl", 0, 0, 32'h0);
      rd_chk("mid_rst_txd", 1, 0, 32'h0);
      rd_chk("mid_rst_rxd", 1, 1, 32'h0);

      // Clean frame after reset; upper TX bits are dropped
      wr_reg(1, 0, 32'hFFFF_FF5A);
      rd_chk("txd_upper", 1, 0, 32'h5A);
      wr_reg(0, 0, 32'h1);
      frame_check("frame_5a", 10'b1_01011010_0, 40, -1, 8'h00, -1);
      rd_chk("5a_send_clr", 0, 0, 32'h0);

      // RX capture, clear, and set-wins-over-clear
      rx_data_i = 8'h3C; rx_valid_i = 1;
      tick();
      rx_valid_i = 0;
      rd_chk("rx_3c", 1, 1, 32'h3C);
      rd_chk("rx_flag", 0, 0, 32'h2);
      wr_reg(0, 0, 32'h0);
      rd_chk("rx_clr", 0, 0, 32'h0);
      wr_reg(0, 0, 32'h2);
      rd_chk("rx_noset", 0, 0, 32'h0);
      rx_data_i = 8'h7E; rx_valid_i = 1;
      wr_reg(0, 0, 32'h0);
      rx_valid_i = 0;
      rd_chk("set_wins", 0, 0, 32'h2);
      rd_chk("rx_7e", 1, 1, 32'h7E);
      wr_reg(1, 1, 32'h11);
      rd_chk("rx_ro", 1, 1, 32'h7E);

      // Second strobe without a clear overwrites and, when enabled, flags overrun
      rx_data_i = 8'h99; rx_valid_i = 1;
      tick();
      rx_valid_i = 0;
      rd_chk("rx_99", 1, 1, 32'h99);
`ifdef OVERRUN_FLAG_EN
      rd_chk("overrun", 0, 0, 32'h6);
`else
      rd_chk("overrun", 0, 0, 32'h2);
`endif
      wr_reg(0, 0, 32'h0);
      rd_chk("ovr_clr", 0, 0, 32'h0);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
